spi_edge_tx: RTL and testbench
==============================

Name: spi_edge_tx

Overview:
SPI peripheral-side transmitter that returns edge-detection results to the MCU over a MISO line (sdo). It is the readback direction of the pixel-upload SPI receiver.
- Buffers edgeVal/X/Y results from edgeDetect in a small FIFO.
- Serialises each result as a 24-bit frame, MSB first, SPI mode 0, while the MCU holds ncs low.
- Runs entirely on mainClk; spiClk and ncs are treated as asynchronous inputs and synchronised.

Parameters:
- FIFO_DEPTH, 16, number of buffered result entries (power of 2, ≥2).
- SYNC_STAGES, 2, synchroniser flops on spiClk and ncs (≥2).

Ports:
- mainClk  input  1  system clock (HSOSC, 12 MHz); must be ≥8× spiClk.
- nreset  input  1  asynchronous active-low reset.
- spiClk  input  1  SPI clock from MCU, idle low.
- ncs  input  1  active-low chip select from MCU.
- sdo  output  1  MISO data.
- sdoEn  output  1  high while selected (tri-state enable at pad).
- edgeVal  input  2  edge result.
- edgeXVal  input  10  pixel x.
- edgeYVal  input  9  pixel y.
- edgeValValid  input  1  push strobe, one mainClk cycle per result.
- fifoCount  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- fifoFull  output  1  fifoCount == FIFO_DEPTH.
- overflow  output  1  sticky; a push was dropped.
- frameDone  output  1  one-cycle pulse per completed frame.

Behaviour:
- Reset values: sdo=0, sdoEn=0, fifoCount=0, fifoFull=0, overflow=0, frameDone=0. FSM enters IDLE; FIFO pointers and bit counter are cleared. Reset mid-frame aborts the frame and empties the FIFO.
- Synchronisation: spiClk and ncs each pass through SYNC_STAGES flops plus one history flop.
  - sclkRise / sclkFall / csFall / csRise are single-cycle edge pulses on the synchronised signals.
- Frame format, bits [23:0]:
  - [23:22] edgeVal
  - [21] valid (1 = FIFO entry, 0 = idle frame)
  - [20:19] 2'b00
  - [18:10] y
  - [9:0] x
  - An idle frame is all zeros.
- FIFO push: when edgeValValid=1 and the FIFO is not full, store {edgeVal, y, x} at the tail.
  - Push while full with no same-cycle pop: entry dropped, overflow set to 1, cleared only by reset.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; fifoCount is unchanged.
- FSM states:
  - IDLE: sdoEn=0, sdo=0. On csFall go to LOAD.
  - LOAD (1 cycle):
    - Shift register ← head frame (peek, no pop) if the FIFO is non-empty, else the idle frame.
    - Record loadedValid. bitCount ← 0. sdo ← frame[23]. sdoEn=1. Go to SHIFT.
  - SHIFT:
    - On sclkRise: bitCount++.
    - On sclkFall with bitCount in 1..23: shift left; sdo ← new MSB.
    - When bitCount reaches 24: pulse frameDone the next cycle, and pop the FIFO if loadedValid; remain in SHIFT.
    - On the first sclkFall after bitCount==24: reload as in LOAD (back-to-back frames within one ncs assertion).
    - On csRise in any state: go to IDLE immediately; sdoEn=0 and sdo=0 in the following cycle.
- Abort rules:
  - ncs deasserted before bitCount==24: no pop and no frameDone; the entry is resent on the next transaction.
  - ncs deasserted after bitCount==24: the pop already occurred.
- Latency:
  - Raw ncs falling to valid sdo: SYNC_STAGES+2 mainClk cycles.
  - Raw spiClk falling to next sdo bit: SYNC_STAGES+2 cycles.
  - The MCU must allow this (≤ 4 cycles = 333 ns at 12 MHz) before the first rising edge.
- sdoEn mirrors the synchronised ncs (inverted) in SHIFT/LOAD; it is never asserted in IDLE.
- The head entry is captured at load, so pushes during a frame never alter the bits being shifted.

Test Plan:
1. Reset with nreset=0 mid-traffic → all outputs 0, fifoCount=0; after release, a 24-clock read returns the idle frame 0x000000.
2. Push edgeVal=2'b10, x=321, y=200; then a 24-clock read at spiClk=1 MHz → sampled on rising edges 0xA32141; frameDone pulses once; fifoCount goes 1→0.
3. Push 3 entries; one ncs assertion with 72 clocks → three frames in push order, each with bit21=1; fifoCount reaches 0; three frameDone pulses.
4. Push 1 entry, deassert ncs after 10 clocks → no pop, fifoCount=1; the next full read returns the same frame intact.
5. Push 17 entries with no reads (FIFO_DEPTH=16) → fifoFull=1, overflow=1, fifoCount=16; a full drain returns entries 1–16 in order.
6. FIFO full, push in the same cycle as a frame-complete pop → fifoCount stays 16, overflow stays 0, and the new entry is read last.

Source files
------------

// File: rtl/spi_edge_tx.sv
// spi_edge_tx
// SPI peripheral-side transmitter (MISO readback of edge-detection results).
// Results pushed by edgeDetect are queued in a small FIFO and serialised as
// 24-bit frames, MSB first, SPI mode 0, while the MCU holds ncs low.
// Everything runs on mainClk; spiClk and ncs are synchronised and edge-detected.
//
// Frame layout [23:0]: {edgeVal[1:0], valid, 2'b00, y[8:0], x[9:0]}.
// An empty FIFO at load time yields the all-zero idle frame.
//
// Ports:
//   mainClk      system clock (must be >= 8x spiClk)
//   nreset       asynchronous active-low reset
//   spiClk, ncs  raw SPI clock / chip select from the MCU (asynchronous)
//   sdo, sdoEn   MISO data and pad tri-state enable
//   edgeVal, edgeXVal, edgeYVal, edgeValValid   result push interface
//   fifoCount, fifoFull, overflow               FIFO status (overflow sticky)
//   frameDone    one-cycle pulse per completed 24-bit frame
//   fsmState     current FSM state (0=IDLE, 1=LOAD, 2=SHIFT) for observation
//
// Handshake: edgeValValid is a one-cycle push strobe with no back-pressure;
// a strobe that finds the FIFO full (and no same-cycle pop) is dropped and
// sets overflow.
module spi_edge_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        mainClk,
    input  logic                        nreset,
    input  logic                        spiClk,
    input  logic                        ncs,
    output logic                        sdo,
    output logic                        sdoEn,
    input  logic [1:0]                  edgeVal,
    input  logic [9:0]                  edgeXVal,
    input  logic [8:0]                  edgeYVal,
    input  logic                        edgeValValid,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        fifoFull,
    output logic                        overflow,
    output logic                        frameDone,
    output logic [1:0]                  fsmState
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // ---------------- synchronisers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_hist;
    logic                   cs_hist;

    // ncs chain resets high (deselected) so reset release never fakes a csFall.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            sclk_sync <= '0;
            sclk_hist <= 1'b0;
            cs_sync   <= '1;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spiClk};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ncs};
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign cs_fall   = ~cs_s & cs_hist;
    assign cs_rise   = cs_s & ~cs_hist;

    // ---------------- FIFO ----------------
    logic [20:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;

    state_t        state;
    logic [23:0]   shreg;
    logic [4:0]    bit_cnt;
    logic          loaded_valid;

    assign fifo_empty = (fifoCount == '0);
    assign fifoFull   = (fifoCount == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok    = edgeValValid & (~fifoFull | pop);

    // The pop fires on the rising edge that completes bit 24, unless the same
    // cycle aborts the frame.
    assign pop = (state == SHIFT) & sclk_rise & ~cs_rise &
                 (bit_cnt == 5'd23) & loaded_valid;

    always_ff @(posedge mainClk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {edgeVal, edgeYVal, edgeXVal};
        end
    end

    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (edgeValValid && fifoFull && !pop) overflow <= 1'b1;
        end
    end

    // Head entry is peeked (not popped) at load time.
    logic [20:0] head;
    logic [23:0] load_frame;

    assign head       = mem[rd_ptr];
    assign load_frame = fifo_empty ? 24'h000000 : {head[20:19], 1'b1, 2'b00, head[18:0]};

    // ---------------- FSM ----------------
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            loaded_valid <= 1'b0;
            sdo          <= 1'b0;
            sdoEn        <= 1'b0;
            frameDone    <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
                sdo   <= 1'b0;
                sdoEn <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sdo   <= 1'b0;
                        sdoEn <= 1'b0;
                        if (cs_fall) state <= LOAD;
                    end
                    LOAD: begin
                        shreg        <= load_frame;
                        loaded_valid <= ~fifo_empty;
                        bit_cnt      <= '0;
                        sdo          <= load_frame[23];
                        sdoEn        <= ~cs_s;
                        state        <= SHIFT;
                    end
                    SHIFT: begin
                        sdoEn <= ~cs_s;
                        if (sclk_rise && bit_cnt < 5'd24) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd23) frameDone <= 1'b1;
                        end else if (sclk_fall) begin
                            if (bit_cnt == 5'd24) begin
                                // Back-to-back frame inside one ncs assertion.
                                shreg        <= load_frame;
                                loaded_valid <= ~fifo_empty;
                                bit_cnt      <= '0;
                                sdo          <= load_frame[23];
                            end else if (bit_cnt != 5'd0) begin
                                shreg <= {shreg[22:0], 1'b0};
                                sdo   <= shreg[22];
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sdo   <= 1'b0;
                        sdoEn <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fsmState = state;

endmodule

// File: tb/tb_spi_edge_tx.sv
`timescale 1ns/1ps
module tb_spi_edge_tx;

    // ---------------- clock / reset ----------------
    logic        mainClk = 1'b0;
    logic        nreset  = 1'b0;
    logic        spiClk  = 1'b0;
    logic        ncs     = 1'b1;
    logic        sdo, sdoEn;
    logic [1:0]  edgeVal = '0;
    logic [9:0]  edgeXVal = '0;
    logic [8:0]  edgeYVal = '0;
    logic        edgeValValid = 1'b0;
    logic [4:0]  fifoCount;
    logic        fifoFull, overflow, frameDone;
    logic [1:0]  fsmState;

    always #5 mainClk = ~mainClk;

    spi_edge_tx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .mainClk(mainClk), .nreset(nreset), .spiClk(spiClk), .ncs(ncs),
        .sdo(sdo), .sdoEn(sdoEn),
        .edgeVal(edgeVal), .edgeXVal(edgeXVal), .edgeYVal(edgeYVal),
        .edgeValValid(edgeValValid),
        .fifoCount(fifoCount), .fifoFull(fifoFull), .overflow(overflow),
        .frameDone(frameDone), .fsmState(fsmState)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] rx_q[$];
    logic [1:0]  inj_e;
    logic [9:0]  inj_x;
    logic [8:0]  inj_y;

    always @(negedge mainClk) if (frameDone) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk_frame(input logic [1:0] e, input logic [9:0] x,
                                             input logic [8:0] y);
        return {e, 1'b1, 2'b00, y, x};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge mainClk);
        nreset = 1'b0;
        repeat (3) @(negedge mainClk);
        nreset = 1'b1;
        repeat (3) @(negedge mainClk);
    endtask

    task automatic push_entry(input logic [1:0] e, input logic [9:0] x,
                              input logic [8:0] y, input bit keep);
        @(negedge mainClk);
        edgeVal = e; edgeXVal = x; edgeYVal = y; edgeValValid = 1'b1;
        @(negedge mainClk);
        edgeValValid = 1'b0;
        if (keep) exp_q.push_back(mk_frame(e, x, y));
    endtask

    // Mode-0 master: sample sdo just before each rising edge, spiClk half period
    // of 5 mainClk cycles. With push_last set, a push strobe is placed on the
    // cycle in which the final rising edge becomes visible inside the DUT
    // (two synchroniser flops, then the history compare).
    task automatic spi_xfer(input int nbits, input bit push_last);
        logic [23:0] cur;
        cur = '0;
        @(negedge mainClk);
        ncs = 1'b0;
        repeat (8) @(negedge mainClk);
        for (int i = 0; i < nbits; i++) begin
            cur = {cur[22:0], sdo};
            spiClk = 1'b1;
            if (push_last && i == nbits - 1) begin
                repeat (2) @(negedge mainClk);
                edgeVal = inj_e; edgeXVal = inj_x; edgeYVal = inj_y; edgeValValid = 1'b1;
                @(negedge mainClk);
                edgeValValid = 1'b0;
                repeat (2) @(negedge mainClk);
            end else begin
                repeat (5) @(negedge mainClk);
            end
            spiClk = 1'b0;
            repeat (5) @(negedge mainClk);
            if ((i % 24) == 23) rx_q.push_back(cur);
        end
        ncs = 1'b1;
        repeat (6) @(negedge mainClk);
    endtask

    task automatic check_frames(input string tag);
        logic [23:0] got, exp;
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'h000000;
            chk(tag, {8'h00, got}, {8'h00, exp});
        end
    endtask

    // ---------------- directed tests ----------------
    int d0;

    initial begin
        do_reset();

        // 1: reset in the middle of traffic
        push_entry(2'd1, 10'd11, 9'd22, 1'b0);
        push_entry(2'd2, 10'd33, 9'd44, 1'b0);
        @(negedge mainClk);
        ncs = 1'b0;
        repeat (8) @(negedge mainClk);
        for (int i = 0; i < 3; i++) begin
            spiClk = 1'b1; repeat (5) @(negedge mainClk);
            spiClk = 1'b0; repeat (5) @(negedge mainClk);
        end
        nreset = 1'b0;
        #1;
        chk("rst_sdo", {31'd0, sdo}, 32'd0);
        chk("rst_sdoEn", {31'd0, sdoEn}, 32'd0);
        chk("rst_count", {27'd0, fifoCount}, 32'd0);
        chk("rst_full", {31'd0, fifoFull}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, frameDone}, 32'd0);
        ncs = 1'b1; spiClk = 1'b0;
        repeat (4) @(negedge mainClk);
        nreset = 1'b1;
        repeat (4) @(negedge mainClk);
        chk("rst_count_after", {27'd0, fifoCount}, 32'd0);
        spi_xfer(24, 1'b0);
        check_frames("idle_frame");

        // 2: single entry
        push_entry(2'b10, 10'd321, 9'd200, 1'b1);
        chk("t2_count1", {27'd0, fifoCount}, 32'd1);
        chk("t2_model", {8'h00, exp_q[0]}, 32'h00A32141);
        d0 = done_cnt;
        spi_xfer(24, 1'b0);
        check_frames("t2_frame");
        chk("t2_done", done_cnt - d0, 32'd1);
        chk("t2_count0", {27'd0, fifoCount}, 32'd0);

        // 3: three frames in one ncs assertion
        for (int i = 0; i < 3; i++)
            push_entry(2'(i + 1), 10'(100 + i * 7), 9'(50 + i * 3), 1'b1);
        d0 = done_cnt;
        spi_xfer(72, 1'b0);
        check_frames("t3_frame");
        chk("t3_done", done_cnt - d0, 32'd3);
        chk("t3_count0", {27'd0, fifoCount}, 32'd0);

        // 4: aborted frame is resent intact
        push_entry(2'b01, 10'd1023, 9'd511, 1'b1);
        d0 = done_cnt;
        spi_xfer(10, 1'b0);
        chk("t4_nopop", {27'd0, fifoCount}, 32'd1);
        chk("t4_nodone", done_cnt - d0, 32'd0);
        chk("t4_sdoEn_idle", {31'd0, sdoEn}, 32'd0);
        spi_xfer(24, 1'b0);
        check_frames("t4_frame");
        chk("t4_count0", {27'd0, fifoCount}, 32'd0);

        // 5: overflow on 17th push, then full drain
        for (int i = 0; i < 17; i++)
            push_entry(2'(i % 4), 10'(i * 37 + 5), 9'(i * 11 + 3), i < 16);
        chk("t5_full", {31'd0, fifoFull}, 32'd1);
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        chk("t5_count", {27'd0, fifoCount}, 32'd16);
        d0 = done_cnt;
        spi_xfer(16 * 24, 1'b0);
        check_frames("t5_frame");
        chk("t5_done", done_cnt - d0, 32'd16);
        chk("t5_count0", {27'd0, fifoCount}, 32'd0);
        chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);

        // 6: push while full in the same cycle as the frame-complete pop
        do_reset();
        exp_q.delete();
        chk("t6_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 16; i++)
            push_entry(2'(3 - i % 4), 10'(i * 19 + 1), 9'(i * 13 + 7), 1'b1);
        chk("t6_full", {31'd0, fifoFull}, 32'd1);
        inj_e = 2'b11; inj_x = 10'd777; inj_y = 9'd333;
        exp_q.push_back(mk_frame(inj_e, inj_x, inj_y));
        spi_xfer(24, 1'b1);
        chk("t6_count", {27'd0, fifoCount}, 32'd16);
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        check_frames("t6_first");
        spi_xfer(16 * 24, 1'b0);
        check_frames("t6_drain");
        chk("t6_count0", {27'd0, fifoCount}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
